// File: rtl/wb_stage_controller.sv
// ---------------------------------------------------------------------------
// wb_stage_controller
//
// Write-back stage sequencer. It accepts one instruction at a time, decodes
// the opcode and issues a single-cycle register-file write:
//   ADD (opcode 1) : writes the ALU result on the cycle after accept.
//   LW  (opcode 2) : waits for the load response and writes the load data on
//                    the cycle after the response arrives. If no response
//                    arrives within MEM_TIMEOUT cycles, the load is abandoned
//                    and timeout_err pulses.
//   other opcodes  : accepted and dropped. They cause no write.
//
// Ports
//   clk, rst_n                 clock and asynchronous active-low reset
//   in_valid / in_ready        instruction handshake (ready only in IDLE)
//   instr, alu_result          instruction word and its ALU result
//   mem_rsp_valid/_data        load response
//   rf_we, rf_waddr, rf_wdata  register-file write port
//   mem_alu_sel                1 = write data came from memory, 0 = from ALU
//   timeout_err                one-cycle pulse on the last unanswered cycle
//   wb_count                   saturating count of performed writes
// ---------------------------------------------------------------------------
module wb_stage_controller #(
    parameter int DATA_W             = 32,
    parameter int OPC_W              = 4,
    parameter int REG_AW             = 4,
    parameter int MEM_TIMEOUT        = 16,
    parameter bit ZERO_REG_HARDWIRED = 1'b1,
    parameter int CNT_W              = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              mem_alu_sel,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  wb_count
);

    localparam int TMO_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
    localparam logic [OPC_W-1:0] OPC_ADD  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OPC_LW   = OPC_W'(2);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        WRITE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rd_q;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              accept;
    logic              tmo_hit;

    // The low instruction bits carry operands this stage does not use.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[DATA_W-OPC_W-REG_AW-1:0];

    assign opcode   = instr[DATA_W-1 -: OPC_W];
    assign rd       = instr[DATA_W-OPC_W-1 -: REG_AW];
    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    // A response on the final waiting cycle wins over the timeout.
    assign tmo_hit = (state == WAIT_MEM) && !mem_rsp_valid && (tmo_cnt == TMO_LAST);

    // The error pulse marks the last WAIT_MEM cycle itself, which is
    // MEM_TIMEOUT cycles after the accept.
    assign timeout_err = tmo_hit;

    // WRITE is always traversed. Only the enable is masked for the zero
    // register, so the timing is the same whatever rd is.
    assign rf_we = (state == WRITE) && !(ZERO_REG_HARDWIRED && (rf_waddr == '0));

    // NOTE: every combinational output gets a default before the case;
    // a path that leaves state_nxt unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept && (opcode == OPC_ADD)) begin
                    state_nxt = WRITE;
                end else if (accept && (opcode == OPC_LW)) begin
                    state_nxt = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                if (mem_rsp_valid) begin
                    state_nxt = WRITE;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
            end
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The write-port registers change only when WRITE is entered, so they
    // hold their last value at all other times. mem_alu_sel also flips when
    // a load is accepted, because it names the source of the pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q        <= '0;
            tmo_cnt     <= '0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            mem_alu_sel <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept && (opcode == OPC_ADD)) begin
                        rf_waddr    <= rd;
                        rf_wdata    <= alu_result;
                        mem_alu_sel <= 1'b0;
                    end else if (accept && (opcode == OPC_LW)) begin
                        rd_q        <= rd;
                        tmo_cnt     <= '0;
                        mem_alu_sel <= 1'b1;
                    end
                end
                WAIT_MEM: begin
                    if (mem_rsp_valid) begin
                        rf_waddr <= rd_q;
                        rf_wdata <= mem_rsp_data;
                    end else if (!tmo_hit) begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_count <= '0;
        end else if (rf_we && (wb_count != {CNT_W{1'b1}})) begin
            wb_count <= wb_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/wb_stage_controller.md
WB_STAGE_CONTROLLER -- requirements
Module: wb_stage_controller

Interface
REQ-001 Parameters (name, default, meaning), one per line, SHALL be:
- DATA_W, 32, instruction/data width.
- OPC_W, 4, opcode width; opcode = instr[DATA_W-1 -: OPC_W].
- REG_AW, 4, destination register address width; rd = instr[DATA_W-OPC_W-1 -: REG_AW].
- MEM_TIMEOUT, 16, maximum WAIT_MEM cycles; must be >= 2.
- ZERO_REG_HARDWIRED, 1, suppresses writes to rd==0 when set.
- CNT_W, 16, retired-write counter width.
REQ-002 Ports (name, direction, width, meaning), one per line, SHALL be:
- clk, in, 1, single clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, instruction offered.
- in_ready, out, 1, controller can accept.
- instr, in, DATA_W, instruction word.
- alu_result, in, DATA_W, ALU result accompanying instr.
- mem_rsp_valid, in, 1, load data valid.
- mem_rsp_data, in, DATA_W, load data.
- rf_we, out, 1, register-file write enable.
- rf_waddr, out, REG_AW, write address.
- rf_wdata, out, DATA_W, write data.
- mem_alu_sel, out, 1, 1 = write data from memory, 0 = from ALU.
- timeout_err, out, 1, one-cycle pulse on a load timeout.
- wb_count, out, CNT_W, saturating count of performed writes.

Function
REQ-003 Opcode decode SHALL be: 1 = ADD (write ALU result); 2 = LW (write memory data); all others (SW, BEQ, JUMP, none) = no write.
REQ-004 FSM states SHALL be IDLE, WAIT_MEM and WRITE; in_ready = 1 only in IDLE.
REQ-005 An accept SHALL be in_valid && in_ready; on accept, rd is registered and, for ADD, alu_result is registered.
REQ-006 IDLE transitions: accept ADD -> WRITE with mem_alu_sel = 0; accept LW -> WAIT_MEM with timeout counter = 0 and mem_alu_sel = 1; accept other -> stay IDLE with no output change.
REQ-007 WAIT_MEM: mem_rsp_valid = 1 SHALL capture mem_rsp_data and go to WRITE; otherwise the counter increments.
REQ-008 WAIT_MEM timeout: when the counter equals MEM_TIMEOUT-1 and mem_rsp_valid = 0, the block SHALL pulse timeout_err for one cycle, return to IDLE and perform no write.
REQ-009 A response in the same cycle as the timeout condition SHALL win: data captured, no error.
REQ-010 WRITE SHALL assert rf_we for exactly one cycle, with rf_waddr and rf_wdata held stable, and go to IDLE next cycle.
REQ-011 ADD latency SHALL be: accept in cycle N -> rf_we in cycle N+1. LW latency: response in cycle M -> rf_we in cycle M+1.
REQ-012 If ZERO_REG_HARDWIRED = 1 and rd = 0, the FSM SHALL still traverse WRITE, but rf_we SHALL stay 0 and wb_count SHALL not increment.
REQ-013 wb_count SHALL increment on each cycle rf_we = 1 and saturate at 2^CNT_W-1.
REQ-014 mem_rsp_valid outside WAIT_MEM SHALL be ignored.
REQ-015 instr and alu_result SHALL be ignored when there is no accept.
REQ-016 rf_waddr, rf_wdata and mem_alu_sel SHALL hold their last value outside WRITE.

Reset
REQ-017 While rst_n = 0, asynchronously: state = IDLE; rf_we = 0; rf_waddr = 0; rf_wdata = 0; mem_alu_sel = 0; timeout_err = 0; wb_count = 0; timeout counter = 0.
REQ-018 Reset asserted mid-operation (WAIT_MEM or WRITE) SHALL abort the operation with no write; in_ready = 1 in the first clock after rst_n rises.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- ADD: instr = 0x13xxxxxx, alu_result = 0xDEADBEEF, accepted cycle N -> cycle N+1: rf_we = 1, rf_waddr = 3, rf_wdata = 0xDEADBEEF, mem_alu_sel = 0; wb_count = 1.
- LW: instr = 0x25xxxxxx, response 0x12345678 three cycles after accept -> one cycle later: rf_we = 1, rf_waddr = 5, rf_wdata = 0x12345678, mem_alu_sel = 1; in_ready = 0 throughout.
- LW with no response -> timeout_err pulses exactly once, MEM_TIMEOUT cycles after accept; no rf_we; back in IDLE. Repeat with the response on the final cycle -> write, no error.
- ADD to rd = 0 -> rf_we stays 0, wb_count unchanged; repeat with ZERO_REG_HARDWIRED = 0 -> write occurs.
- Opcodes 0 and 3..15 back-to-back -> in_ready stays 1, never rf_we; a stray mem_rsp_valid in IDLE has no effect.
- rst_n pulsed low in WAIT_MEM, then the response arrives -> no write, all outputs at reset values; CNT_W = 2 with 5 writes -> wb_count = 3.
